// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_pkg
//  Description : Shared constants for the ALU EX->WB pipeline. Holds the
//                default field widths and the payload bit-packing (field
//                offsets and total payload width).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pipe_pkg;

    // Default field widths
    localparam int DEF_WFID_W      = 6;
    localparam int DEF_PC_W        = 32;
    localparam int DEF_VGPR_ADDR_W = 10;
    localparam int DEF_SGPR_ADDR_W = 9;

    // Single-bit flags packed at the top of the payload
    localparam int FLG_DONE    = 0;
    localparam int FLG_VGPR_WE = 1;
    localparam int FLG_SGPR_WE = 2;
    localparam int FLG_VCC_WE  = 3;
    localparam int FLAGS_W     = 4;

    // Payload layout, LSB first: wfid | pc | vgpr | sgpr | flags.
    // wfid sits at bit 0 so the flush compare always reads a fixed slice.
    localparam int OFF_WFID = 0;

    function automatic int pl_off_pc(input int wfid_w);
        return wfid_w;
    endfunction

    function automatic int pl_off_vgpr(input int wfid_w, input int pc_w);
        return wfid_w + pc_w;
    endfunction

    function automatic int pl_off_sgpr(input int wfid_w, input int pc_w,
                                       input int vgpr_w);
        return wfid_w + pc_w + vgpr_w;
    endfunction

    function automatic int pl_off_flags(input int wfid_w, input int pc_w,
                                        input int vgpr_w, input int sgpr_w);
        return wfid_w + pc_w + vgpr_w + sgpr_w;
    endfunction

    function automatic int payload_width(input int wfid_w, input int pc_w,
                                         input int vgpr_w, input int sgpr_w);
        return pl_off_flags(wfid_w, pc_w, vgpr_w, sgpr_w) + FLAGS_W;
    endfunction

    localparam int DEF_PAYLOAD_W = payload_width(DEF_WFID_W, DEF_PC_W,
                                                 DEF_VGPR_ADDR_W, DEF_SGPR_ADDR_W);

endpackage : alu_pipe_pkg
`default_nettype wire

// File: rtl/alu_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_stage
//  Description : One elastic slot of the EX->WB pipeline. Loads from upstream
//                whenever it is empty or its own entry moves on, otherwise
//                holds. A flush hit clears the held entry at the edge and
//                hides it from downstream in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_stage
    import alu_pipe_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,           // asynchronous, active low
    input  logic                 valid_i,       // upstream entry (already flush-masked)
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 dn_advance_i,  // downstream takes an entry this cycle
    input  logic                 flush_hit_i,   // held entry matches the flushed wfid
    output logic                 valid_o,       // raw slot valid
    output logic                 live_o,        // valid and not being flushed
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic                 advance_o      // slot loads from upstream this cycle
);

    logic                 valid_q;
    logic                 valid_d;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [PAYLOAD_W-1:0] payload_d;

    // An empty slot always accepts; a full one only if its entry moves on.
    assign advance_o = ~valid_q | dn_advance_i;
    assign live_o    = valid_q & ~flush_hit_i;
    assign valid_o   = valid_q;
    assign payload_o = payload_q;

    // Next state: take upstream on advance, otherwise keep the (flush-masked) entry.
    always_comb begin
        valid_d   = live_o;
        payload_d = payload_q;
        if (advance_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                payload_d = payload_i;
            end
        end
    end

    // Slot registers; payload only changes when a live entry is loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

endmodule : alu_pipe_stage
`default_nettype wire

// File: rtl/alu_ex_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ex_wb_pipe
//  Description : Parametrised elastic EX->WB pipeline for the ALU writeback
//                bundle with valid/ready backpressure, per-wavefront flush
//                and occupancy reporting.
//                Optional macro ALU_EX_WB_PIPE_STALL_CNT_EN adds a 16-bit
//                saturating output-stall counter on port stall_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ex_wb_pipe
    import alu_pipe_pkg::*;
#(
    parameter int STAGES      = 2,
    parameter int WFID_W      = DEF_WFID_W,
    parameter int PC_W        = DEF_PC_W,
    parameter int VGPR_ADDR_W = DEF_VGPR_ADDR_W,
    parameter int SGPR_ADDR_W = DEF_SGPR_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,               // asynchronous, active low
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WFID_W-1:0]            in_wfid,
    input  logic [PC_W-1:0]              in_instr_pc,
    input  logic [VGPR_ADDR_W-1:0]       in_vgpr_dest_addr,
    input  logic [SGPR_ADDR_W-1:0]       in_sgpr_dest_addr,
    input  logic                         in_instr_done,
    input  logic                         in_vgpr_wr_en,
    input  logic                         in_sgpr_wr_en,
    input  logic                         in_vcc_wr_en,
    input  logic                         flush_en,
    input  logic [WFID_W-1:0]            flush_wfid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WFID_W-1:0]            out_wfid,
    output logic [PC_W-1:0]              out_instr_pc,
    output logic [VGPR_ADDR_W-1:0]       out_vgpr_dest_addr,
    output logic [SGPR_ADDR_W-1:0]       out_sgpr_dest_addr,
    output logic                         out_instr_done,
    output logic                         out_vgpr_dest_wr_en,
    output logic                         out_sgpr_dest_wr_en,
    output logic                         out_vcc_wr_en,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
`ifdef ALU_EX_WB_PIPE_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int OCC_W     = $clog2(STAGES + 1);
    localparam int OFF_PC    = pl_off_pc(WFID_W);
    localparam int OFF_VGPR  = pl_off_vgpr(WFID_W, PC_W);
    localparam int OFF_SGPR  = pl_off_sgpr(WFID_W, PC_W, VGPR_ADDR_W);
    localparam int OFF_FLAGS = pl_off_flags(WFID_W, PC_W, VGPR_ADDR_W, SGPR_ADDR_W);
    localparam int PAYLOAD_W = payload_width(WFID_W, PC_W, VGPR_ADDR_W, SGPR_ADDR_W);

    if (STAGES < 1) begin : g_stages_check
        $error("alu_ex_wb_pipe: STAGES must be >= 1");
    end

    logic [PAYLOAD_W-1:0] w_in_payload;
    logic                 w_in_hit;
    logic [STAGES-1:0]    w_slot_valid;
    logic [STAGES-1:0]    w_slot_live;
    logic [STAGES-1:0]    w_slot_adv;
    logic [STAGES-1:0]    w_slot_hit;
    logic [STAGES-1:0]    w_slot_vin;
    logic [STAGES-1:0]    w_slot_dn_adv;
    logic [PAYLOAD_W-1:0] w_slot_pin [STAGES];
    logic [PAYLOAD_W-1:0] w_slot_pl  [STAGES];
    logic [PAYLOAD_W-1:0] w_last_pl;
    logic [OCC_W-1:0]     w_occ;

    assign w_in_payload = {in_vcc_wr_en, in_sgpr_wr_en, in_vgpr_wr_en, in_instr_done,
                           in_sgpr_dest_addr, in_vgpr_dest_addr, in_instr_pc, in_wfid};

    // A flushed wavefront arriving this cycle is accepted but never written valid.
    assign w_in_hit = flush_en & (in_wfid == flush_wfid);

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign w_slot_vin[i] = in_valid & ~w_in_hit;
            assign w_slot_pin[i] = w_in_payload;
        end else begin : g_body
            assign w_slot_vin[i] = w_slot_live[i-1];
            assign w_slot_pin[i] = w_slot_pl[i-1];
        end

        if (i == STAGES - 1) begin : g_tail
            assign w_slot_dn_adv[i] = out_ready;
        end else begin : g_mid
            assign w_slot_dn_adv[i] = w_slot_adv[i+1];
        end

        assign w_slot_hit[i] = flush_en & (w_slot_pl[i][OFF_WFID +: WFID_W] == flush_wfid);

        alu_pipe_stage #(
            .PAYLOAD_W (PAYLOAD_W)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .valid_i      (w_slot_vin[i]),
            .payload_i    (w_slot_pin[i]),
            .dn_advance_i (w_slot_dn_adv[i]),
            .flush_hit_i  (w_slot_hit[i]),
            .valid_o      (w_slot_valid[i]),
            .live_o       (w_slot_live[i]),
            .payload_o    (w_slot_pl[i]),
            .advance_o    (w_slot_adv[i])
        );
    end

    // Handshake: the ready chain runs combinationally from out_ready to slot 0.
    assign in_ready  = w_slot_adv[0];
    assign out_valid = w_slot_live[STAGES-1];
    assign w_last_pl = w_slot_pl[STAGES-1];

    assign out_wfid            = w_last_pl[OFF_WFID +: WFID_W];
    assign out_instr_pc        = w_last_pl[OFF_PC   +: PC_W];
    assign out_vgpr_dest_addr  = w_last_pl[OFF_VGPR +: VGPR_ADDR_W];
    assign out_sgpr_dest_addr  = w_last_pl[OFF_SGPR +: SGPR_ADDR_W];
    assign out_instr_done      = w_last_pl[OFF_FLAGS + FLG_DONE]    & out_valid;
    assign out_vgpr_dest_wr_en = w_last_pl[OFF_FLAGS + FLG_VGPR_WE] & out_valid;
    assign out_sgpr_dest_wr_en = w_last_pl[OFF_FLAGS + FLG_SGPR_WE] & out_valid;
    assign out_vcc_wr_en       = w_last_pl[OFF_FLAGS + FLG_VCC_WE]  & out_valid;

    // Occupancy is the popcount of the registered slot valids (current state).
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + OCC_W'(w_slot_valid[i]);
        end
    end

    assign occupancy = w_occ;

`ifdef ALU_EX_WB_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Count cycles where WB holds off a valid bundle; saturates, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : alu_ex_wb_pipe
`default_nettype wire

// File: doc/alu_ex_wb_pipe.md
Name: alu_ex_wb_pipe

Overview:
- Parametrised, elastic EX->WB pipeline for the ALU writeback bundle. It carries wfid, PC, VGPR/SGPR destination, done flag and write enables.
- Supersedes the fixed single-flop bundle. Adds configurable depth, valid/ready backpressure, per-wavefront flush and occupancy reporting.
- Sits between ALU execute output and the VGPR/SGPR/VCC writeback arbiter.

Parameters:
- STAGES, 2, number of register slots (>=1; elaboration error otherwise)
- WFID_W, 6, wavefront id width
- PC_W, 32, instruction PC width
- VGPR_ADDR_W, 10, VGPR destination address width
- SGPR_ADDR_W, 9, SGPR destination address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  EX bundle valid
- in_ready  out  1  pipe accepts bundle this cycle
- in_wfid  in  WFID_W  wavefront id
- in_instr_pc  in  PC_W  instruction PC
- in_vgpr_dest_addr  in  VGPR_ADDR_W  VGPR destination
- in_sgpr_dest_addr  in  SGPR_ADDR_W  SGPR destination
- in_instr_done  in  1  instruction-complete flag
- in_vgpr_wr_en / in_sgpr_wr_en / in_vcc_wr_en  in  1 each  write enables
- flush_en  in  1  kill entries of flush_wfid
- flush_wfid  in  WFID_W  wavefront to kill
- out_valid  out  1  WB bundle valid
- out_ready  in  1  WB consumes bundle
- out_wfid, out_instr_pc, out_vgpr_dest_addr, out_sgpr_dest_addr, out_instr_done  out  as inputs  last-stage payload
- out_vgpr_dest_wr_en / out_sgpr_dest_wr_en / out_vcc_wr_en  out  1 each  write enables, gated by out_valid
- occupancy  out  $clog2(STAGES+1)  count of valid slots
- stall_cnt  out  16  present only with ALU_EX_WB_PIPE_STALL_CNT_EN

Behaviour:
Reset:
- rst low clears all slot valids and payloads to 0, asynchronously.
- out_valid=0, all out_* =0, occupancy=0, stall_cnt=0.
- Reset mid-transfer discards all contents; no output on the first cycle after release.

Slots:
- Slot 0 is the input and slot STAGES-1 is the output. Each slot holds valid plus payload.
- Slot i advances to slot i+1 when slot i+1 is empty or slot i+1 advances. The last slot advances when out_ready.
- Bubbles collapse.
- Latency: exactly STAGES cycles from accepted input to out_valid, when unstalled.
- Throughput: one bundle per cycle.

Handshake:
- in_ready = slot0 empty OR slot0 advances. It is combinational from out_ready through the chain.
- Transfer occurs when in_valid & in_ready, and out_valid & out_ready respectively.
- Payload in a stalled slot holds stable.
- out_* payload fields are driven directly from the last slot.
- Write-enable outputs and out_instr_done are ANDed with out_valid.

Flush:
- When flush_en, every slot whose wfid==flush_wfid has its valid cleared at the clock edge.
- The masking is also combinational on out_valid in the same cycle, so WB never consumes a flushed entry.
- A matching input accepted that cycle is dropped (not written valid). in_ready is unaffected by flush.
- If flush and advance coincide, flush wins for matching entries; non-matching entries move normally.
- Flushed slots count as empty for the next cycle's advance.

Occupancy:
- Registered popcount of slot valids after the edge, i.e. current state. Range 0..STAGES.

Boundaries:
- Full pipe with out_ready=0 gives in_ready=0.
- Full pipe with out_ready=1 gives in_ready=1 (simultaneous in/out).
- Empty pipe gives out_valid=0 and occupancy=0.

Optional Feature:
ALU_EX_WB_PIPE_STALL_CNT_EN
- Defined: port stall_cnt exists. It is a 16-bit counter incremented each cycle out_valid & ~out_ready, saturating at 16'hFFFF. It is cleared only by reset.
- Undefined: port and counter logic absent; all other behaviour identical.

Decomposition:
- Shared package/include alu_pipe_pkg holds:
  - default width constants (WFID_W, PC_W, VGPR_ADDR_W, SGPR_ADDR_W)
  - the payload bit-packing (field offsets and total payload width)
- Sub-module alu_pipe_stage is one slot, instantiated STAGES times via generate. Its ports are:
  - inputs: valid/payload in, downstream advance, flush match
  - outputs: valid/payload out, advance

Test Plan:
- STAGES=2, out_ready=1, send wfid 3, pc 0x100, vgpr_wr_en=1 -> out_valid after 2 cycles with identical payload, occupancy peaks at 2 or fewer, in_ready stays 1.
- out_ready=0, send 3 bundles into STAGES=2 -> in_ready drops after 2 accepts, occupancy=2. Then out_ready=1 -> bundles exit in order, one per cycle, with in_ready=1 on the same cycle.
- Fill slots with wfid 5 and 7, assert flush_en with flush_wfid=5 -> wfid-5 entries vanish (out_valid low the same cycle if wfid 5 is in the last slot), wfid-7 entry delivered, occupancy decremented.
- Input wfid 5 with in_valid while flush_en and flush_wfid=5 -> in_ready=1 but entry never appears at output.
- Assert rst low mid-stream with a full pipe -> all outputs 0 immediately. After release, out_valid stays 0 until new input plus STAGES cycles.
- With ALU_EX_WB_PIPE_STALL_CNT_EN, hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and holds.
